// File: rtl/mem_dump_reader_if.sv
// Bus bundle for mem_dump_reader: memory read port plus the valid/ready word stream.
// master = the reader, slave = memory model / stream sink.
interface mem_dump_reader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_data_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output mem_addr, mem_rd_en, out_valid, out_data, out_addr, out_last,
    input  mem_data_out, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, out_valid, out_data, out_addr, out_last,
    output mem_data_out, out_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// Sequential memory read-back engine streaming NUM_WORDS words over valid/ready.
// Optional running checksum of accepted words enabled by DUMP_CHECKSUM_EN.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | waiting for first start
// S_ISSUE   | mem_rd_en high, mem_addr = current word address
// S_CAPTURE | memory data valid, latched into out_* registers
// S_PRESENT | out_valid high, waiting for out_ready
// S_DONE    | dump complete, done high until next start
module mem_dump_reader #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                NUM_WORDS  = 256,
  parameter int                WORD_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mem_dump_reader_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     checksum
);
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_PRESENT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_last_q;
  logic              start_ok;
  logic              accept;
  logic              last_word;
  logic [ADDR_W-1:0] addr_next;

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept    = (state_q == S_PRESENT) && bus.out_ready;
  assign last_word = (cnt_q == CNT_W'(NUM_WORDS - 1));
  assign addr_next = addr_q + ADDR_W'(WORD_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_PRESENT;
      S_PRESENT: if (bus.out_ready) state_d = out_last_q ? S_DONE : S_ISSUE;
      S_DONE:    if (start) state_d = S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en = (state_q == S_ISSUE);
    bus.out_valid = (state_q == S_PRESENT);
    busy          = (state_q == S_ISSUE) || (state_q == S_CAPTURE) || (state_q == S_PRESENT);
    done          = (state_q == S_DONE);
  end

  // mem_addr is loaded on the way into ISSUE so it holds the last read address afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q     <= BASE_ADDR;
        mem_addr_q <= BASE_ADDR;
        cnt_q      <= '0;
      end
      if (state_q == S_CAPTURE) begin
        out_data_q <= bus.mem_data_out;
        out_addr_q <= addr_q;
        out_last_q <= last_word;
      end
      if (accept) begin
        addr_q <= addr_next;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (!out_last_q) mem_addr_q <= addr_next;
      end
    end
  end

  assign bus.mem_addr = mem_addr_q;
  assign bus.out_data = out_data_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_last = out_last_q;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        checksum_q <= '0;
    else if (start_ok) checksum_q <= '0;
    else if (accept)   checksum_q <= checksum_q + out_data_q;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: scenario table, random dumps vs. a
// queue-based reference model, and hand-written latency/reset/wrap sequences.
module tb_mem_dump_reader;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct {
    logic [3:0][31:0] img;
    int               stall_word;
    int               stall_len;
    bit               rnd_ready;
    bit               spam;
    logic [31:0]      exp_sum;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] sum0, sum1, sum2;

  mem_dump_reader_if if0 ();
  mem_dump_reader_if if1 ();
  mem_dump_reader_if if2 ();

  mem_dump_reader #(.BASE_ADDR(32'h0), .NUM_WORDS(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(if0.master),
    .busy(busy0), .done(done0), .checksum(sum0));
  mem_dump_reader #(.BASE_ADDR(32'hFFFF_FFFC), .NUM_WORDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(if1.master),
    .busy(busy1), .done(done1), .checksum(sum1));
  mem_dump_reader #(.BASE_ADDR(32'hFFFF_FFFC), .NUM_WORDS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(if2.master),
    .busy(busy2), .done(done2), .checksum(sum2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] img0 [0:15];
  word_t got_q[$], got1_q[$], got2_q[$], exp_q[$];
  int reads0 = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // memories: data valid only in the cycle after a read strobe
  always @(posedge clk) begin
    if0.mem_data_out <= if0.mem_rd_en ? img0[if0.mem_addr[5:2]] : 32'hDEAD_BEEF;
    if1.mem_data_out <= if1.mem_rd_en ? mem_fn(if1.mem_addr) : 32'hDEAD_BEEF;
    if2.mem_data_out <= if2.mem_rd_en ? mem_fn(if2.mem_addr) : 32'hDEAD_BEEF;
  end

  // handshake seen at negedge completes at the following posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.out_valid && if0.out_ready) got_q.push_back('{if0.out_addr, if0.out_data, if0.out_last});
      if (if1.out_valid && if1.out_ready) got1_q.push_back('{if1.out_addr, if1.out_data, if1.out_last});
      if (if2.out_valid && if2.out_ready) got2_q.push_back('{if2.out_addr, if2.out_data, if2.out_last});
      if (if0.mem_rd_en) reads0++;
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_checksum(input logic [31:0] s);
`ifdef DUMP_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  // reference: word i lives at base + 4*i (mod 2^32), last only on word n-1
  task automatic build_exp(input logic [31:0] base, input int n, input bit use_img);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      exp_q.push_back('{a, use_img ? img0[a[5:2]] : mem_fn(a), (i == n - 1)});
    end
  endtask

  function automatic logic [31:0] model_sum();
    logic [31:0] s = 0;
    foreach (exp_q[i]) s += exp_q[i].data;
    return s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_addr"}, if0.mem_addr, 0);
    chk({tag, "_mem_rd_en"}, if0.mem_rd_en, 0);
    chk({tag, "_out_valid"}, if0.out_valid, 0);
    chk({tag, "_out_data"}, if0.out_data, 0);
    chk({tag, "_out_addr"}, if0.out_addr, 0);
    chk({tag, "_out_last"}, if0.out_last, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_checksum"}, sum0, 0);
  endtask

  task automatic wait_done0(input string tag, input int max_cycles);
    bit fin = 0;
    for (int c = 0; c < max_cycles && !fin; c++) begin
      if (done0) fin = 1;
      else begin @(posedge clk); #1; end
    end
    chk({tag, "_timeout"}, fin, 1);
  endtask

  task automatic run_dump(input logic [3:0][31:0] img, input int stall_word, input int stall_len,
                          input bit rnd_ready, input bit spam);
    int stalled = 0;
    bit fin = 0;
    for (int i = 0; i < 4; i++) img0[i] = img[i];
    build_exp(32'h0, 4, 1'b1);
    got_q.delete();
    reads0 = 0;
    start0 = 1'b1;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (done0) fin = 1;
      else begin
        if (if0.out_valid && got_q.size() == stall_word && stalled < stall_len) begin
          if0.out_ready = 1'b0;
          stalled++;
          chk("hold_data", if0.out_data, exp_q[stall_word].data);
          chk("hold_addr", if0.out_addr, exp_q[stall_word].addr);
        end else begin
          if0.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        start0 = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
    end
    start0 = 1'b0;
    if0.out_ready = 1'b1;
    chk("dump_timeout", fin, 1);
  endtask

  task automatic compare_dump(input logic [31:0] exp_sum);
    chk("word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("word%0d_addr", i), got_q[i].addr, exp_q[i].addr);
      chk($sformatf("word%0d_data", i), got_q[i].data, exp_q[i].data);
      chk($sformatf("word%0d_last", i), got_q[i].last, exp_q[i].last);
    end
    chk("read_count", reads0, exp_q.size());
    chk("done_after", done0, 1);
    chk("busy_after", busy0, 0);
    chk("checksum", sum0, exp_checksum(exp_sum));
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{'{32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1'b0, 1'b0, 32'hAA};
    vecs[1] = '{'{32'h44, 32'h33, 32'h22, 32'h11}, 1, 5, 1'b0, 1'b0, 32'hAA};
    vecs[2] = '{'{32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1'b0, 1'b1, 32'hAA};
    vecs[3] = '{'{32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF}, 2, 3, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{'{32'hEDCB_A987, 32'h0, 32'h1111_1111, 32'h1234_5678}, -1, 0, 1'b1, 1'b1, 32'h1111_1110};
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) img0[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // latency: start sampled at edge k -> rd_en after k -> out_valid after k+2
    img0[0] = 32'h11; img0[1] = 32'h22; img0[2] = 32'h33; img0[3] = 32'h44;
    build_exp(32'h0, 4, 1'b1);
    got_q.delete(); reads0 = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("lat_rd_en", if0.mem_rd_en, 1);
    chk("lat_mem_addr", if0.mem_addr, 0);
    chk("lat_busy", busy0, 1);
    @(posedge clk); #1;
    chk("lat_rd_en_off", if0.mem_rd_en, 0);
    chk("lat_valid_early", if0.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", if0.out_valid, 1);
    chk("lat_data", if0.out_data, 32'h11);
    chk("lat_last", if0.out_last, 0);
    wait_done0("lat", 40);
    compare_dump(32'hAA);

    // restart from DONE clears done on the next cycle
    got_q.delete(); reads0 = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("restart_done", done0, 0);
    chk("restart_rd_en", if0.mem_rd_en, 1);
    wait_done0("restart", 40);
    compare_dump(32'hAA);

    foreach (vecs[v]) begin
      run_dump(vecs[v].img, vecs[v].stall_word, vecs[v].stall_len, vecs[v].rnd_ready, vecs[v].spam);
      compare_dump(vecs[v].exp_sum);
    end

    for (int r = 0; r < 4; r++) begin
      logic [3:0][31:0] rimg;
      for (int i = 0; i < 4; i++) rimg[i] = $urandom;
      run_dump(rimg, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)));
      compare_dump(model_sum());
    end

    // reset while word 3 is presented
    img0[0] = 32'h11; img0[1] = 32'h22; img0[2] = 32'h33; img0[3] = 32'h44;
    got_q.delete();
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int c = 0; c < 40 && !(if0.out_valid && got_q.size() == 2); c++) begin
      @(posedge clk); #1;
    end
    if0.out_ready = 1'b0;
    chk("pre_reset_word3", {if0.out_valid, if0.out_data}, {1'b1, 32'h33});
    #2 rst_n = 1'b0;
    #1 chk_reset("mid");
    chk("mid_accepts", got_q.size(), 2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy0, done0}, 2'b00);
    run_dump({32'h44, 32'h33, 32'h22, 32'h11}, -1, 0, 1'b0, 1'b0);
    compare_dump(32'hAA);

    // wrap: single word and two words from the top of the address space
    got1_q.delete(); got2_q.delete();
    start1 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int c = 0; c < 40 && !(done1 && done2); c++) begin
      @(posedge clk); #1;
    end
    chk("nw1_done", done1, 1);
    build_exp(32'hFFFF_FFFC, 1, 1'b0);
    chk("nw1_count", got1_q.size(), 1);
    if (got1_q.size() == 1) chk("nw1_word", got1_q[0], exp_q[0]);
    chk("nw1_checksum", sum1, exp_checksum(model_sum()));
    chk("nw2_done", done2, 1);
    build_exp(32'hFFFF_FFFC, 2, 1'b0);
    chk("nw2_count", got2_q.size(), 2);
    for (int i = 0; i < got2_q.size() && i < 2; i++)
      chk($sformatf("nw2_word%0d", i), got2_q[i], exp_q[i]);
    chk("nw2_checksum", sum2, exp_checksum(model_sum()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
